// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - line-wide memory responder with fixed access latency
//
// Main-memory side of the cache line transfer. One read (fill) or write
// (writeback) request is accepted at a time. The request is latched on
// acceptance and held for a fixed number of cycles. The write is then
// committed, or the read line is captured into rdata. After that, done
// pulses for one cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (storage contents untouched)
//   req_valid  request present; level, held by the requester until done
//   req_we     1 = line write, 0 = line read
//   req_addr   byte address; offset bits and bits above the index are ignored
//   wdata      line data for writes
//   busy       high whenever a request is in flight (state != IDLE)
//   done       one-cycle completion pulse
//   rdata      last read line; updated only when a read completes

module line_mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [LINE_W-1:0] rdata
);

    localparam int OFF   = $clog2(LINE_W / 8);
    localparam int IDX   = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    // Counter value on the edge that leaves WAIT
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic              last_wait;

    logic [IDX-1:0]    lat_idx;
    logic              lat_we;
    logic [LINE_W-1:0] lat_wdata;

    logic [LINE_W-1:0] mem [DEPTH];

    // Only the index field of the address is used; the rest is deliberately dropped
    logic              addr_unused;
    assign addr_unused = ^req_addr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_wait = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (count == LAST_CNT) begin
                    last_wait = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // req_valid is ignored here; a held request is taken in IDLE
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // ------------------------------------------------------------------
    // Latency counter and request latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (accept) begin
            count <= CNT_W'(1);
        end else if (state == ST_WAIT) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

    // Inputs are sampled only at acceptance; changes during WAIT are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_idx   <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_idx   <= req_addr[OFF+IDX-1:OFF];
            lat_we    <= req_we;
            lat_wdata <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Line storage: no reset. The commit happens on the edge into DONE,
    // so a read accepted right after done already sees the new line.
    // A reset on the commit edge wins, so an interrupted write is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && last_wait && lat_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

    // Read line register: changes only when a read completes
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (last_wait && !lat_we) begin
            rdata <= mem[lat_idx];
        end
    end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Main-memory side of the cache-to-memory line transfer; it is the responder to the cache controller's writeback and fill requests.
- It accepts one line-wide read or write request, models a fixed multi-cycle access latency, then commits the write or returns the read line with a one-cycle done pulse.
- It sits between the cache datapath (line buffer, mem_we / mem_in_select muxing) and the line storage array.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, line width in bits (4 x 32-bit words); must be a multiple of 8.
- DEPTH, 256, number of lines stored; power of two.
- LATENCY, 4, cycles from request acceptance to done; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; level, held by the requester until done.
- req_we  in  1  1 = line write (writeback), 0 = line read (fill).
- req_addr  in  ADDR_W  byte address of the line.
- wdata  in  LINE_W  line data for writes.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  LINE_W  read line; valid in the done cycle and held until the next read completes.

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE, counter = 0, done = 0, busy = 0, rdata = 0.
  - Storage array contents are not affected by reset.
- Address mapping:
  - OFF = log2(LINE_W/8), IDX = log2(DEPTH).
  - index = req_addr[OFF+IDX-1:OFF].
  - Offset bits are ignored, so unaligned addresses map to their containing line.
  - Upper bits are ignored, so addresses wrap modulo DEPTH lines.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If req_valid is sampled high at edge T, latch addr index, req_we and wdata, set counter = 1, and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - counter increments each edge.
  - At the edge where counter == LATENCY-1, go to DONE.
  - On that same edge, if we: array[index] <= latched wdata; else rdata <= array[index].
  - Changes to req_valid, req_addr or wdata while in WAIT are ignored; only latched values are used.
- DONE:
  - done = 1 for exactly this cycle.
  - Next edge returns to IDLE unconditionally; req_valid sampled in DONE is ignored.
- Timing:
  - done is high in cycle T+LATENCY, where T is the acceptance edge.
  - Back-to-back throughput is one request per LATENCY+1 cycles.
  - The requester must drop req_valid in the cycle after done, or a new request is accepted in IDLE.
- Write/read ordering:
  - A write is committed before done rises.
  - A read issued in the IDLE cycle right after a write's done returns the new data.
- rdata changes only on read completion; write completions leave it unchanged.
- Reset mid-operation (rst in WAIT or DONE):
  - Return to IDLE.
  - An in-flight write whose commit edge has not occurred is dropped, with no array update.
  - done stays 0.
- rst has priority over every other event on the same edge.
- Storage is a simple registered array with no byte enables; whole-line writes only.

Test Plan:
- Reset then read: rst 2 cycles; read addr 0x40 at edge T -> busy=1 from T+1, done=1 only at cycle T+4, rdata = preloaded line 4.
- Write then read-back: write addr 0x100, wdata 0x0123_4567_89AB_CDEF_0011_2233_4455_6677; after done, read 0x100 -> rdata equals that value at done; a second read of 0x0F0 returns different contents.
- Wrap and offset: with DEPTH=256, write 0x1000 (index 0) with 0xAA..AA; read 0x0000 and 0x000C -> both return 0xAA..AA.
- Input stability: change req_addr and wdata every cycle during WAIT -> only the values latched at acceptance are used; no extra done pulses.
- Back-to-back with req_valid held high through done -> second request accepted on the IDLE edge after DONE; done pulses spaced exactly 5 cycles apart.
- Reset mid-write: write 0x200 with 0xFF..FF, assert rst at counter == 2 -> busy=0 and done=0 next cycle; a later read of 0x200 returns the old contents.
